// File: rtl/stream_demux_1_to_n.sv
// Registered 1-to-N packet demux; channel locked from in_sel on a packet's first beat.
// Latency 1 cycle; one holding register gives full throughput when the selected channel is ready.
// Backpressure: in_ready = !full || out_ready[held chan]; STREAM_DEMUX_DROP_EN drops out-of-range packets.
module stream_demux_1_to_n #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
`ifdef STREAM_DEMUX_DROP_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  lock_chan, hold_chan, sel_chan, beat_chan;
    logic [DATA_W-1:0] hold_data;
    logic              hold_last, full;
    logic              sel_oor, accept, load, pop;

    // Widen before comparing so a power-of-two N_OUT never wraps to zero.
    assign sel_oor   = 32'(in_sel) >= 32'(N_OUT);
    assign sel_chan  = sel_oor ? SEL_W'(N_OUT - 1) : in_sel;
    assign beat_chan = (state == PKT) ? lock_chan : sel_chan;
    assign pop       = full && out_ready[hold_chan];

`ifdef STREAM_DEMUX_DROP_EN
    logic drop_first, drop_beat;

    assign in_ready   = (state == DROP) || !full || out_ready[hold_chan];
    assign accept     = in_valid && in_ready;
    assign drop_first = accept && (state == IDLE) && sel_oor;
    assign drop_beat  = drop_first || (accept && (state == DROP));
    assign load       = accept && !drop_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'h0000;
        end else if (drop_first && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end
    end
`else
    assign in_ready = !full || out_ready[hold_chan];
    assign accept   = in_valid && in_ready;
    assign load     = accept;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
`ifdef STREAM_DEMUX_DROP_EN
                    state_nxt = sel_oor ? DROP : PKT;
`else
                    state_nxt = PKT;
`endif
                end
            end
            PKT:     if (accept && in_last) state_nxt = IDLE;
            DROP:    if (accept && in_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_chan <= '0;
            hold_chan <= '0;
            hold_data <= '0;
            hold_last <= 1'b0;
            full      <= 1'b0;
        end else begin
            if ((state == IDLE) && accept) begin
                lock_chan <= sel_chan;
            end
            if (load) begin
                hold_data <= in_data;
                hold_last <= in_last;
                hold_chan <= beat_chan;
            end
            // A pop and a load in the same cycle keep the register full.
            full <= load || (full && !pop);
        end
    end

    assign out_valid = full ? (N_OUT'(1) << hold_chan) : '0;
    assign out_data  = hold_data;
    assign out_last  = hold_last;
    assign busy      = (state != IDLE) || full;

endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Bench for stream_demux_1_to_n: table-driven beats with a queue scoreboard, plus reset and N_OUT=5 sequences.
module tb_stream_demux_1_to_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid, in_ready, in_last, out_last, busy;
    logic [7:0] in_data, out_valid, out_ready, out_data;
    logic [2:0] in_sel;

    logic       v5, rdy5, l5, ol5, busy5;
    logic [7:0] d5, od5;
    logic [2:0] s5;
    logic [4:0] ov5, or5;
`ifdef STREAM_DEMUX_DROP_EN
    logic [15:0] drop_cnt, dc5;
`endif

    always #5 clk = ~clk;

    stream_demux_1_to_n #(.DATA_W(8), .N_OUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
`ifdef STREAM_DEMUX_DROP_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    stream_demux_1_to_n #(.DATA_W(8), .N_OUT(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(rdy5),
        .in_data(d5), .in_last(l5), .in_sel(s5),
        .out_valid(ov5), .out_ready(or5), .out_data(od5),
        .out_last(ol5), .busy(busy5)
`ifdef STREAM_DEMUX_DROP_EN
        , .drop_cnt(dc5)
`endif
    );

    typedef struct {
        logic       v;
        logic [2:0] sel;
        logic [7:0] data;
        logic       last;
        logic [7:0] ordy;
        logic [2:0] exp_chan;
        logic       exp_rdy;
        logic       chk_busy;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic [2:0] chan;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic [7:0] d,
                                input logic last, input logic [7:0] ordy, input logic [2:0] ch,
                                input logic rdy, input logic cb, input logic eb);
        vec_t r;
        r.v = v; r.sel = sel; r.data = d; r.last = last; r.ordy = ordy;
        r.exp_chan = ch; r.exp_rdy = rdy; r.chk_busy = cb; r.exp_busy = eb;
        return r;
    endfunction

    // Head of the scoreboard must be on the outputs in every cycle after it was accepted.
    task automatic monitor_cycle();
        if (sbq.size() > 0) begin
            check("out_valid", out_valid, 32'd1 << sbq[0].chan);
            check("out_data", out_data, sbq[0].data);
            check("out_last", out_last, sbq[0].last);
            if (out_ready[sbq[0].chan]) void'(sbq.pop_front());
        end else begin
            check("idle out_valid", out_valid, 32'd0);
        end
    endtask

    task automatic apply(input vec_t r);
        in_valid  = r.v;
        in_sel    = r.sel;
        in_data   = r.data;
        in_last   = r.last;
        out_ready = r.ordy;
        #1;
        check("in_ready", in_ready, r.exp_rdy);
        if (r.chk_busy) check("busy", busy, r.exp_busy);
        monitor_cycle();
        if (in_valid && in_ready) sbq.push_back('{r.exp_chan, r.data, r.last});
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] sels5 [4];
        logic       lasts5[4];
        in_valid = 0; in_sel = 0; in_data = 0; in_last = 0; out_ready = 8'hFF;
        v5 = 0; s5 = 0; d5 = 0; l5 = 0; or5 = 5'h1F;

        // Pass-through: single beats to every channel.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 3'(i), 8'hA0 + 8'(i), 1, 8'hFF, 3'(i), 1, i < 2, i == 1));
        // Lock: in_sel changes mid-packet are ignored.
        vecs.push_back(mk(1, 3, 8'h10, 0, 8'hFF, 3, 1, 0, 0));
        vecs.push_back(mk(1, 5, 8'h11, 0, 8'hFF, 3, 1, 1, 1));
        vecs.push_back(mk(1, 6, 8'h12, 0, 8'hFF, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 8'h13, 1, 8'hFF, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'hFF, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'hFF, 0, 1, 1, 0));
        // Backpressure: channel 2 stalled for 5 cycles, all others ready.
        vecs.push_back(mk(1, 2, 8'h20, 0, 8'hFB, 2, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 5, 8'h21, 0, 8'hFB, 2, 0, 1, 1));
        vecs.push_back(mk(1, 5, 8'h21, 0, 8'hFF, 2, 1, 0, 0));
        vecs.push_back(mk(1, 7, 8'h22, 1, 8'hFF, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'hFF, 0, 1, 0, 0));
        // Back-to-back packets switching channel with no bubble.
        vecs.push_back(mk(1, 1, 8'h31, 1, 8'hFF, 1, 1, 0, 0));
        vecs.push_back(mk(1, 6, 8'h32, 1, 8'hFF, 6, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'hFF, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'hFF, 0, 1, 1, 0));

        #12;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        check("reset busy", busy, 0);
`ifdef STREAM_DEMUX_DROP_EN
        check("reset drop_cnt", drop_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("in_ready after reset", in_ready, 1);

        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-packet to ch4: lock and held beat must be discarded.
        apply(mk(1, 4, 8'h41, 0, 8'hFF, 4, 1, 0, 0));
        apply(mk(1, 2, 8'h42, 0, 8'hFF, 4, 1, 0, 0));
        #2 rst_n = 0;
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset out_data", out_data, 0);
        check("mid reset out_last", out_last, 0);
        check("mid reset busy", busy, 0);
        sbq.delete();
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        apply(mk(0, 0, 8'h00, 0, 8'hFF, 0, 1, 1, 0));
        apply(mk(1, 0, 8'h55, 1, 8'hFF, 0, 1, 0, 0));
        apply(mk(0, 0, 8'h00, 0, 8'hFF, 0, 1, 0, 0));
        apply(mk(0, 0, 8'h00, 0, 8'hFF, 0, 1, 1, 0));
        check("scoreboard drained", sbq.size(), 0);

        // N_OUT=5: out-of-range selects clamp to ch4, or are dropped with the macro.
        sels5  = '{3'd6, 3'd1, 3'd1, 3'd7};
        lasts5 = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            v5 = 1; s5 = sels5[i]; d5 = 8'h61 + 8'(i); l5 = lasts5[i];
            #1;
            check("n5 in_ready", rdy5, 1);
            @(negedge clk);
`ifdef STREAM_DEMUX_DROP_EN
            check("n5 out_valid", ov5, 0);
            check("n5 drop_cnt", dc5, (i < 3) ? 1 : 2);
`else
            check("n5 out_valid", ov5, 5'b10000);
            check("n5 out_data", od5, 8'h61 + 8'(i));
            check("n5 out_last", ol5, lasts5[i]);
`endif
        end
        v5 = 0;
        @(negedge clk);
        check("n5 drained", ov5, 0);
`ifdef STREAM_DEMUX_DROP_EN
        check("n5 drop_cnt final", dc5, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1_to_n.md
# stream_demux_1_to_n

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking and packet-locked routing. It is the successor to the team's combinational 1-to-8 bit demux: it adds configurable width and channel count, backpressure, and per-packet channel locking. It sits between a single upstream packet source and N downstream consumers, with one cycle of latency.

## Interface
- `DATA_W`, default 8: payload width in bits, 1..64.
- `N_OUT`, default 8: output channel count, 2..16.
- `SEL_W`, default `$clog2(N_OUT)`: select width. Derived; do not override.

Ports:
- `clk` input 1: clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: upstream beat valid.
- `in_ready` output 1: upstream beat accepted when `in_valid && in_ready`.
- `in_data` input DATA_W: beat payload.
- `in_last` input 1: final beat of the packet.
- `in_sel` input SEL_W: destination channel; sampled only on the first beat of a packet.
- `out_valid` output N_OUT: per-channel valid; at most one bit is set.
- `out_ready` input N_OUT: per-channel ready.
- `out_data` output DATA_W: shared payload bus; meaningful only for the channel whose `out_valid` bit is set.
- `out_last` output 1: last flag of the held beat.
- `busy` output 1: high while a packet is open or the holding register is full.
- `drop_cnt` output 16: dropped-packet count; present only with `STREAM_DEMUX_DROP_EN`.

## Operation
- Routing state machine:
  - `IDLE`: no packet open. A first beat is accepted with `in_last=0` → the channel latches from `in_sel` and the state moves to `PKT`. A first beat accepted with `in_last=1` is a single-beat packet and the state stays `IDLE`.
  - `PKT`: all beats go to the latched channel and `in_sel` is ignored. An accepted beat with `in_last=1` → `IDLE`.
- Holding register: one entry holding `{data, last, chan}`.
  - The entry loads on an accepted beat.
  - It empties when `out_valid[chan] && out_ready[chan]`.
- Ready rule: `in_ready = !full || out_ready[chan_held]`, which permits pass-through at full throughput.
  - `in_ready` must not depend on `in_valid`.
  - `out_valid` must not depend on any `out_ready`.
- Held data and `out_valid` stay stable while the selected channel stalls. Stalls on other channels have no effect.
- Simultaneous pop and load in one cycle: the register takes the new beat and `full` stays 1.
- Out-of-range select (`in_sel >= N_OUT`, possible only when N_OUT is not a power of 2): without the macro, the channel clamps to N_OUT-1.
- Reset mid-packet: the lock is discarded, the holding register empties, and the state returns to `IDLE`. The next accepted beat is treated as a first beat.

## Timing
- Reset values:
  - `out_valid`, `out_data`, `out_last`, `busy` and `drop_cnt` reset to 0.
  - `in_ready` is 1 one cycle after reset release, and combinationally 1 while the register is empty.
- Latency: a beat accepted at edge k is visible on `out_*` after edge k.
- Throughput: 1 beat/cycle when the selected channel holds `out_ready=1`.
- Channel switch between back-to-back packets: no bubble. The last beat of packet A and the first beat of packet B may occupy consecutive cycles.
- `busy` is 0 only when the state is `IDLE` and the register is empty.

## Configuration
- `STREAM_DEMUX_DROP_EN` defined:
  - A first beat with `in_sel >= N_OUT` opens a dropped packet.
  - Every beat up to and including `in_last` is accepted (`in_ready=1`) and discarded, and nothing loads.
  - `drop_cnt` increments once per dropped packet, in the cycle the first beat is accepted, and saturates at 16'hFFFF.
  - A dropped single-beat packet also counts.
- Undefined: the `drop_cnt` port is absent, no drop logic is built, and out-of-range selects clamp to N_OUT-1.

## Test plan
- **Pass-through, single beats:** N_OUT=8, DATA_W=8, all `out_ready=1`; single-beat packets with sel=0..7, data 8'hA0+sel. Required: beat i appears one cycle later on `out_valid=8'b1<<sel` with `out_data=8'hA0+sel`, `out_last=1`, and no bubbles.
- **Lock:** 4-beat packet with sel=3 on the first beat, then `in_sel` changed to 5, 6, 1. Required: all 4 beats on channel 3 (`out_valid=8'b0000_1000`), `out_last` only on beat 4, and `busy` falling after the final pop.
- **Backpressure:** channel 2 `out_ready=0` for 5 cycles during a 3-beat packet, with `out_ready=1` on all other channels. Required:
  - `in_ready=0` after the first beat loads.
  - `out_data` is held constant through the stall.
  - No beat is lost or duplicated after release.
- **Back-to-back channel switch:** packet to ch1 (last=1) immediately followed by packet to ch6. Required: consecutive cycles show `out_valid=8'h02` then `8'h40`.
- **Reset mid-packet:** assert `rst_n=0` asynchronously after beat 2 of a 4-beat packet to ch4. Required:
  - Outputs are 0 immediately.
  - After release, a beat with sel=0 and last=1 routes to ch0.
- **Drop (macro on, N_OUT=5):** 3-beat packet with sel=6, then a single beat with sel=7. Required: `in_ready=1` throughout, `out_valid` stays 0, and `drop_cnt` reads 1 then 2. With the macro off, the same stimulus routes to ch4.
